// File: rtl/cycpuf_crp_collector.sv
// rtl/cycpuf_crp_collector.sv - LFSR challenge driver and majority-vote CRP collector
// Drives a cyclic arbiter PUF and streams {challenge, voted response} records.
module cycpuf_crp_collector #(
   parameter int          SETTLE_CYC = 4,
   parameter int          VOTES      = 5,
   parameter logic [36:0] SEED       = 37'h15A5A5A5A5,
   localparam int         VW         = $clog2(VOTES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [15:0]   num_crp,
   output logic [36:0]   chal_o,
   input  logic          resp_i,
   output logic          crp_valid,
   input  logic          crp_ready,
   output logic [36:0]   crp_chal,
   output logic          crp_resp,
   output logic [VW-1:0] crp_ones,
   output logic          busy,
   output logic          done
);

   localparam int CMAX = (SETTLE_CYC > VOTES) ? SETTLE_CYC : VOTES;
   localparam int CW   = ($clog2(CMAX) < 1) ? 1 : $clog2(CMAX);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, OUTPUT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [VW-1:0] ones_q, ones_d;
   logic [36:0]   lfsr_q, lfsr_d;
   logic [36:0]   chal_q, chal_d;
   logic [15:0]   rem_q, rem_d;
   logic          done_q, done_d;
   logic [36:0]   lfsr_next;

   // Fibonacci LFSR, x^37+x^5+x^4+x^3+x^2+x+1
   assign lfsr_next = {lfsr_q[35:0],
                       lfsr_q[36] ^ lfsr_q[4] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[1] ^ lfsr_q[0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ones_q  <= '0;
         lfsr_q  <= SEED;
         chal_q  <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ones_q  <= ones_d;
         lfsr_q  <= lfsr_d;
         chal_q  <= chal_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ones_d  = ones_q;
      lfsr_d  = lfsr_q;
      chal_d  = chal_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_crp != 16'd0) begin
                  lfsr_d  = SEED;
                  chal_d  = SEED;
                  rem_d   = num_crp;
                  cnt_d   = '0;
                  state_d = SETTLE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYC - 1)) begin
               cnt_d   = '0;
               ones_d  = '0;
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SAMPLE: begin
            ones_d = ones_q + VW'(resp_i);
            if (cnt_q == CW'(VOTES - 1)) begin
               cnt_d   = '0;
               state_d = OUTPUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OUTPUT: begin
            if (crp_ready) begin
               rem_d = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  lfsr_d  = lfsr_next;
                  chal_d  = lfsr_next;
                  state_d = SETTLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Record fields are forced to zero outside OUTPUT so reset clears them at once
   assign crp_valid = (state_q == OUTPUT);
   assign crp_chal  = crp_valid ? chal_q : '0;
   assign crp_ones  = crp_valid ? ones_q : '0;
   assign crp_resp  = crp_valid && (ones_q > VW'(VOTES / 2));
   assign chal_o    = chal_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_cycpuf_crp_collector.sv
// tb/tb_cycpuf_crp_collector.sv - directed self-checking bench for cycpuf_crp_collector
module tb_cycpuf_crp_collector;

   localparam logic [36:0] SEED  = 37'h15A5A5A5A5;
   localparam logic [36:0] STEP1 = 37'h0B4B4B4B4B;
   localparam logic [36:0] STEP2 = 37'h1696969697;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] num_crp;
   logic [36:0] chal_o;
   logic        resp_i;
   logic        crp_valid;
   logic        crp_ready;
   logic [36:0] crp_chal;
   logic        crp_resp;
   logic [2:0]  crp_ones;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   cycpuf_crp_collector dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_crp   (num_crp),
      .chal_o    (chal_o),
      .resp_i    (resp_i),
      .crp_valid (crp_valid),
      .crp_ready (crp_ready),
      .crp_chal  (crp_chal),
      .crp_resp  (crp_resp),
      .crp_ones  (crp_ones),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_valid(input string tag);
      int k;
      k = 0;
      while (crp_valid !== 1'b1 && k < 60) begin
         tick(1);
         k++;
      end
      chk(tag, crp_valid, 1);
   endtask

   function automatic logic [36:0] step(input logic [36:0] l);
      return {l[35:0], l[36] ^ l[4] ^ l[3] ^ l[2] ^ l[1] ^ l[0]};
   endfunction

   initial begin
      logic [4:0]  v;
      logic [36:0] model;
      logic [36:0] seen [200];
      int          dups;
      int          dsnap;
      int          nval;

      rst = 1'b1; start = 1'b0; num_crp = '0; resp_i = 1'b0; crp_ready = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
      chk("rst_chal", chal_o, 0);
      chk("rst_valid", crp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ones", crp_ones, 0);

      // three records, constant 1 response, ready held high
      num_crp = 16'd3; resp_i = 1'b1; crp_ready = 1'b1; start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("t1_busy", busy, 1);
      chk("t1_chal_o", chal_o, SEED);
      tick(8);
      chk("t1_valid_early", crp_valid, 0);
      tick(1);
      chk("t1_valid0", crp_valid, 1);
      chk("t1_chal0", crp_chal, SEED);
      chk("t1_resp0", crp_resp, 1);
      chk("t1_ones0", crp_ones, 5);
      tick(1);
      chk("t1_hs_valid", crp_valid, 0);
      chk("t1_chal_o1", chal_o, STEP1);
      chk("t1_done_mid", done, 0);
      tick(8);
      chk("t1_valid1_early", crp_valid, 0);
      tick(1);
      chk("t1_valid1", crp_valid, 1);
      chk("t1_chal1", crp_chal, STEP1);
      tick(10);
      chk("t1_valid2", crp_valid, 1);
      chk("t1_chal2", crp_chal, STEP2);
      chk("t1_ones2", crp_ones, 5);
      tick(1);
      chk("t1_done", done, 1);
      chk("t1_busy_end", busy, 0);
      chk("t1_valid_end", crp_valid, 0);
      tick(1);
      chk("t1_done_pulse", done, 0);

      // voting 1,1,0,0,0 with a 0->1 glitch during settle
      num_crp = 16'd1; crp_ready = 1'b0; resp_i = 1'b0; start = 1'b1;
      tick(1);
      start = 1'b0;
      resp_i = 1'b0; tick(1); resp_i = 1'b0; tick(1);
      resp_i = 1'b1; tick(1); resp_i = 1'b1; tick(1);
      v = 5'b00011;
      for (int i = 0; i < 5; i++) begin
         resp_i = v[i];
         tick(1);
      end
      chk("v1_valid", crp_valid, 1);
      chk("v1_ones", crp_ones, 2);
      chk("v1_resp", crp_resp, 0);
      crp_ready = 1'b1;
      tick(1);
      chk("v1_done", done, 1);
      chk("v1_valid_end", crp_valid, 0);
      crp_ready = 1'b0;
      tick(2);

      // voting 1,0,1,1,0 then ten cycles of backpressure
      start = 1'b1;
      tick(1);
      start = 1'b0;
      resp_i = 1'b0; tick(1); resp_i = 1'b1; tick(1);
      resp_i = 1'b1; tick(1); resp_i = 1'b1; tick(1);
      v = 5'b01101;
      for (int i = 0; i < 5; i++) begin
         resp_i = v[i];
         tick(1);
      end
      chk("v2_ones", crp_ones, 3);
      chk("v2_resp", crp_resp, 1);
      for (int i = 0; i < 10; i++) begin
         resp_i = ~resp_i;
         tick(1);
         chk("bp_valid", crp_valid, 1);
         chk("bp_chal", crp_chal, SEED);
         chk("bp_ones", crp_ones, 3);
         chk("bp_resp", crp_resp, 1);
         chk("bp_chal_o", chal_o, SEED);
      end
      crp_ready = 1'b1;
      tick(1);
      chk("bp_hs_valid", crp_valid, 0);
      chk("bp_hs_done", done, 1);
      tick(2);

      // num_crp = 0: immediate done, no record
      num_crp = 16'd0; start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("z_done", done, 1);
      chk("z_busy", busy, 0);
      nval = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (crp_valid === 1'b1) nval++;
      end
      chk("z_no_valid", nval, 0);

      // start held high for a 2-record run
      num_crp = 16'd2; resp_i = 1'b1; crp_ready = 1'b1; start = 1'b1;
      dsnap = done_cnt;
      nval = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (crp_valid === 1'b1) nval++;
         if (i == 19) chk("s_chal1", crp_chal, STEP1);
      end
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (crp_valid === 1'b1) nval++;
      end
      chk("s_records", nval, 2);
      chk("s_dones", done_cnt - dsnap, 1);

      // reset during SAMPLE of the second record
      num_crp = 16'd3; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(16);
      dsnap = done_cnt;
      rst = 1'b1;
      #1;
      chk("ar_chal_o", chal_o, 0);
      chk("ar_busy", busy, 0);
      chk("ar_valid", crp_valid, 0);
      chk("ar_chal", crp_chal, 0);
      chk("ar_done", done, 0);
      tick(2);
      rst = 1'b0;
      tick(12);
      chk("ar_no_done", done_cnt - dsnap, 0);
      chk("ar_idle_valid", crp_valid, 0);
      num_crp = 16'd1; start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("ar_restart_chal", chal_o, SEED);
      tick(10);
      chk("ar_restart_done", done, 1);
      tick(2);

      // 200-record run against a reference LFSR
      num_crp = 16'd200; crp_ready = 1'b1; resp_i = 1'b1; start = 1'b1;
      model = SEED;
      tick(1);
      start = 1'b0;
      for (int r = 0; r < 200; r++) begin
         wait_valid("long_valid");
         chk("long_chal", crp_chal, model);
         chk("long_nonzero", crp_chal != 37'd0, 1);
         seen[r] = crp_chal;
         model = step(model);
         tick(1);
      end
      chk("long_done", done, 1);
      chk("long_busy", busy, 0);
      dups = 0;
      for (int a = 0; a < 200; a++)
         for (int b = a + 1; b < 200; b++)
            if (seen[a] == seen[b]) dups++;
      chk("long_norepeat", dups, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
